// File: rtl/mul_hilo_sequencer_pkg.sv
// Shared definitions for the HI/LO multiply sequencer: default sizes and FSM state encoding.
package mul_hilo_sequencer_pkg;

  localparam int unsigned WidthDef   = 32;
  // Must exceed the multiplier worst case of WIDTH+2 cycles.
  localparam int unsigned TimeoutDef = 40;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StIssue = 3'd1,
    StWait  = 3'd2,
    StFixup = 3'd3,
    StWrite = 3'd4
  } state_e;

endpackage

// File: rtl/mul_hilo_sequencer_if.sv
// Bundle of pipeline-side and multiplier-side signals around the HI/LO sequencer.
interface mul_hilo_sequencer_if
  import mul_hilo_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = WidthDef
);

  logic               mul_req;
  logic               mul_signed;
  logic [WIDTH-1:0]   rs_val;
  logic [WIDTH-1:0]   rt_val;
  logic               mthi_we;
  logic               mtlo_we;
  logic [WIDTH-1:0]   wdata;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic               mul_go;
  logic [WIDTH-1:0]   mcand_out;
  logic [WIDTH-1:0]   mplier_out;
  logic               stall;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               mul_err;

  // Sequencer view.
  modport slave (
    input  mul_req, mul_signed, rs_val, rt_val, mthi_we, mtlo_we, wdata, mul_done, mul_product,
    output mul_go, mcand_out, mplier_out, stall, hi, lo, mul_err
  );

  // Pipeline plus multiplier view.
  modport master (
    output mul_req, mul_signed, rs_val, rt_val, mthi_we, mtlo_we, wdata, mul_done, mul_product,
    input  mul_go, mcand_out, mplier_out, stall, hi, lo, mul_err
  );

endinterface

// File: rtl/mul_sign_conv.sv
// Conditional two's-complement negate: y = neg ? -a : a, at any width.
module mul_sign_conv #(
  parameter int unsigned W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

  assign y = neg ? (~a + W'(1)) : a;

endmodule

// File: rtl/mul_hilo_sequencer.sv
// Issue/writeback sequencer for the shift-add multiplier: operand magnitudes, go/done handshake,
// product sign fix-up, HI/LO commit, MTHI/MTLO service and timeout abort.
module mul_hilo_sequencer
  import mul_hilo_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH   = WidthDef,
  parameter int unsigned TIMEOUT = TimeoutDef
) (
  input logic                  clk,
  input logic                  rst,
  mul_hilo_sequencer_if.slave  bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  state_e             state_q;
  logic               neg_q;
  logic               go_q;
  logic               err_q;
  logic [CntW-1:0]    cnt_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [2*WIDTH-1:0] prod_q;

  logic [WIDTH-1:0]   rs_mag;
  logic [WIDTH-1:0]   rt_mag;
  logic [2*WIDTH-1:0] prod_fix;

  mul_sign_conv #(.W(WIDTH)) u_rs_conv (
    .neg (bus.mul_signed & bus.rs_val[WIDTH-1]),
    .a   (bus.rs_val),
    .y   (rs_mag)
  );

  mul_sign_conv #(.W(WIDTH)) u_rt_conv (
    .neg (bus.mul_signed & bus.rt_val[WIDTH-1]),
    .a   (bus.rt_val),
    .y   (rt_mag)
  );

  mul_sign_conv #(.W(2 * WIDTH)) u_prod_conv (
    .neg (neg_q),
    .a   (prod_q),
    .y   (prod_fix)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      neg_q    <= 1'b0;
      go_q     <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      prod_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          // Moves land here even alongside a request; the multiply overwrites them later.
          if (bus.mthi_we) hi_q <= bus.wdata;
          if (bus.mtlo_we) lo_q <= bus.wdata;
          if (bus.mul_req) begin
            mcand_q  <= rs_mag;
            mplier_q <= rt_mag;
            neg_q    <= bus.mul_signed & (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
            err_q    <= 1'b0;
            go_q     <= 1'b1;
            state_q  <= StIssue;
          end
        end
        StIssue: begin
          go_q    <= 1'b0;
          cnt_q   <= '0;
          state_q <= StWait;
        end
        StWait: begin
          if (bus.mul_done) begin
            prod_q  <= bus.mul_product;
            state_q <= StFixup;
          end else if (cnt_q == CntW'(TIMEOUT)) begin
            err_q   <= 1'b1;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StFixup: begin
          prod_q  <= prod_fix;
          state_q <= StWrite;
        end
        StWrite: begin
          hi_q    <= prod_q[2*WIDTH-1:WIDTH];
          lo_q    <= prod_q[WIDTH-1:0];
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.mul_go     = go_q;
  assign bus.mcand_out  = mcand_q;
  assign bus.mplier_out = mplier_q;
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;
  assign bus.mul_err    = err_q;
  assign bus.stall      = (state_q != StIdle) | bus.mul_req;

endmodule

// File: tb/tb_mul_hilo_sequencer.sv
// Randomised self-checking bench for mul_hilo_sequencer with a programmable-latency multiplier model.
module tb_mul_hilo_sequencer;

  localparam int unsigned W  = 32;
  localparam int unsigned TO = 40;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  mul_hilo_sequencer_if #(.WIDTH(W)) bus ();

  mul_hilo_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mag(input logic [W-1:0] v, input logic sgn);
    return (sgn && v[W-1]) ? (W'(0) - v) : v;
  endfunction

  // Architectural result straight from the MULT/MULTU definition.
  function automatic logic [63:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic sgn);
    longint sa;
    longint sb;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    return 64'(sa * sb);
  endfunction

  task automatic drive_idle();
    bus.mul_req     = 1'b0;
    bus.mul_signed  = 1'b0;
    bus.rs_val      = '0;
    bus.rt_val      = '0;
    bus.mthi_we     = 1'b0;
    bus.mtlo_we     = 1'b0;
    bus.wdata       = '0;
    bus.mul_done    = 1'b0;
    bus.mul_product = '0;
  endtask

  task automatic do_move(input bit h, input bit l, input logic [W-1:0] d);
    @(negedge clk);
    bus.mthi_we = h;
    bus.mtlo_we = l;
    bus.wdata   = d;
    if (h) exp_hi = d;
    if (l) exp_lo = d;
    @(negedge clk);
    bus.mthi_we = 1'b0;
    bus.mtlo_we = 1'b0;
    #1;
    check_val("move_hi", 64'(bus.hi), 64'(exp_hi));
    check_val("move_lo", 64'(bus.lo), 64'(exp_lo));
  endtask

  // Cycle k=0 is the request cycle; the model raises done in cycle 1+d (d=0 lands in ISSUE).
  task automatic do_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sgn, input int d, input bit never, input bit move_at_req);
    bit           tmo;
    int           low_at;
    int           go_cnt;
    int           rand_hi;
    logic [63:0]  p;
    logic [W-1:0] mv;
    tmo     = never || (d == 0);
    low_at  = -1;
    go_cnt  = 0;
    rand_hi = tmo ? int'(TO) + 1 : 3 + d;
    p       = ref_product(a, b, sgn);
    mv      = $urandom;
    for (int k = 0; k < int'(TO) + 20; k++) begin
      @(negedge clk);
      bus.mul_req    = (k == 0);
      bus.mul_signed = (k == 0) ? sgn : 1'($urandom);
      bus.rs_val     = (k == 0) ? a : $urandom;
      bus.rt_val     = (k == 0) ? b : $urandom;
      if (k == 0) begin
        bus.mthi_we = move_at_req;
        bus.mtlo_we = 1'b0;
        bus.wdata   = mv;
      end else if (k <= rand_hi) begin
        bus.mthi_we = 1'($urandom);
        bus.mtlo_we = 1'($urandom);
        bus.wdata   = $urandom;
      end else begin
        bus.mthi_we = 1'b0;
        bus.mtlo_we = 1'b0;
      end
      bus.mul_done    = !never && (k == 1 + d);
      bus.mul_product = bus.mul_done ? (64'(bus.mcand_out) * 64'(bus.mplier_out))
                                     : {32'($urandom), 32'($urandom)};
      #1;
      if (bus.mul_go) go_cnt++;
      if (k == 0) check_val({tag, "_stall_req"}, 64'(bus.stall), 64'd1);
      if (k == 1) begin
        check_val({tag, "_mcand"}, 64'(bus.mcand_out), 64'(mag(a, sgn)));
        check_val({tag, "_mplier"}, 64'(bus.mplier_out), 64'(mag(b, sgn)));
        check_val({tag, "_err_clr"}, 64'(bus.mul_err), 64'd0);
        if (move_at_req) check_val({tag, "_move_req"}, 64'(bus.hi), 64'(mv));
      end
      if (k > 0 && !bus.stall) begin
        low_at = k;
        break;
      end
    end
    bus.mul_done = 1'b0;
    check_val({tag, "_go_cnt"}, 64'(go_cnt), 64'd1);
    if (tmo) begin
      if (move_at_req) exp_hi = mv;
      check_val({tag, "_tmo_window"},
                64'(low_at >= int'(TO) + 2 && low_at <= int'(TO) + 3), 64'd1);
      check_val({tag, "_err"}, 64'(bus.mul_err), 64'd1);
    end else begin
      exp_hi = p[63:32];
      exp_lo = p[31:0];
      check_val({tag, "_latency"}, 64'(low_at), 64'(4 + d));
      check_val({tag, "_err"}, 64'(bus.mul_err), 64'd0);
    end
    check_val({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
    check_val({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
  endtask

  initial begin
    drive_idle();
    #2 rst = 1'b1;
    #1;
    check_val("rst_hi", 64'(bus.hi), 64'd0);
    check_val("rst_lo", 64'(bus.lo), 64'd0);
    check_val("rst_mcand", 64'(bus.mcand_out), 64'd0);
    check_val("rst_mplier", 64'(bus.mplier_out), 64'd0);
    check_val("rst_go", 64'(bus.mul_go), 64'd0);
    check_val("rst_err", 64'(bus.mul_err), 64'd0);
    check_val("rst_stall", 64'(bus.stall), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    do_mul("multu_3x5", 32'd3, 32'd5, 1'b0, 34, 1'b0, 1'b0);
    do_mul("mult_m3x5", 32'hFFFF_FFFD, 32'd5, 1'b1, 12, 1'b0, 1'b0);
    do_mul("multu_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 7, 1'b0, 1'b0);
    do_mul("mult_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1, 1'b0, 1'b0);
    do_mul("mult_min", 32'h8000_0000, 32'h8000_0000, 1'b1, int'(TO), 1'b0, 1'b0);

    do_move(1'b1, 1'b1, 32'hCAFE_F00D);
    do_mul("timeout", $urandom, $urandom, 1'b1, 5, 1'b1, 1'b0);
    do_mul("done_in_issue", $urandom, $urandom, 1'b0, 0, 1'b0, 1'b1);
    do_mul("after_tmo", 32'h0001_0000, 32'h0001_0000, 1'b0, 3, 1'b0, 1'b1);
    do_move(1'b0, 1'b1, 32'h0BAD_BEEF);

    for (int i = 0; i < 12; i++) begin
      do_mul($sformatf("rnd%0d", i), $urandom, $urandom, 1'($urandom),
             int'($urandom_range(1, TO)), 1'b0, 1'($urandom));
    end

    do_move(1'b1, 1'b1, 32'h1234_5678);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      bus.mul_req     = (k == 0);
      bus.mul_signed  = 1'b0;
      bus.rs_val      = 32'd7;
      bus.rt_val      = 32'd9;
      bus.mul_done    = (k == 21);
      bus.mul_product = 64'hDEAD_BEEF_0000_1111;
      if (k == 5) rst = 1'b1;
      if (k == 6) rst = 1'b0;
      #1;
      if (k == 5) begin
        check_val("rstmid_hi", 64'(bus.hi), 64'd0);
        check_val("rstmid_lo", 64'(bus.lo), 64'd0);
        check_val("rstmid_stall", 64'(bus.stall), 64'd0);
        check_val("rstmid_mcand", 64'(bus.mcand_out), 64'd0);
      end
    end
    bus.mul_done = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    check_val("stale_done_hi", 64'(bus.hi), 64'd0);
    check_val("stale_done_lo", 64'(bus.lo), 64'd0);
    check_val("stale_done_stall", 64'(bus.stall), 64'd0);
    do_mul("post_rst", 32'hFFFF_FFF0, 32'd16, 1'b1, 9, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
